prim_debounce: RTL and testbench

PRIM_DEBOUNCE -- requirements
Module: prim_debounce

---
 rtl/prim_debounce.sv | 148 ++++++++++++++
 tb/tb_prim_debounce.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_debounce.sv
// Debounce filter for a slow asynchronous level such as a pad or a push button.
//
// Data path:
//   serial_i -> SyncStages-deep synchronizer -> s -> qualification FSM -> serial_o
//
// A candidate transition on s only reaches serial_o once s has held the new level
// for thresh_i+2 consecutive enabled cycles. The FSM has two stable states and two
// checking states, and a stability counter cnt.
//
// Optional feature, controlled by the PRIM_DEBOUNCE_EDGE_EN macro:
//   - defined:   r_edge_o and f_edge_o are registered one-cycle pulses that line up
//                with the first cycle of the new serial_o level.
//   - undefined: both ports are kept but tied to 0, and no edge flops are built.
module prim_debounce #(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned SyncStages = 2   // legal range 2..4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                serial_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic                serial_o,
  output logic                busy_o,
  output logic                r_edge_o,
  output logic                f_edge_o
);

  localparam logic [1:0] StStableLo = 2'd0;
  localparam logic [1:0] StChkHi    = 2'd1;
  localparam logic [1:0] StStableHi = 2'd2;
  localparam logic [1:0] StChkLo    = 2'd3;

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic [1:0]            state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  out_q, out_d;

  // Synchronizer shift chain; it keeps running even while the filter is disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], serial_i};
    end
  end

  assign s = sync_q[SyncStages-1];

  // Next state: qualify a candidate level and reject glitches. The compare is >=,
  // so lowering thresh_i below cnt mid-count completes on the next qualifying cycle.
  // cnt only increments while it is below thresh_i, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      StStableLo: begin
        if (en_i && s) begin
          state_d = StChkHi;
          cnt_d   = '0;
        end
      end
      StChkHi: begin
        if (!en_i || !s) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q >= thresh_i) begin
          state_d = StStableHi;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (en_i && !s) begin
          state_d = StChkLo;
          cnt_d   = '0;
        end
      end
      StChkLo: begin
        if (!en_i || s) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q >= thresh_i) begin
          state_d = StStableLo;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  // State, counter and the debounced output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign serial_o = out_q;
  assign busy_o   = (state_q == StChkHi) || (state_q == StChkLo);

`ifdef PRIM_DEBOUNCE_EDGE_EN
  logic r_edge_q, f_edge_q;

  // Edge pulses are computed from out_d, so they coincide with the first new-level cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_edge_q <= 1'b0;
      f_edge_q <= 1'b0;
    end else begin
      r_edge_q <= out_d & ~out_q;
      f_edge_q <= ~out_d & out_q;
    end
  end

  assign r_edge_o = r_edge_q;
  assign f_edge_o = f_edge_q;
`else
  assign r_edge_o = 1'b0;
  assign f_edge_o = 1'b0;
`endif

`ifndef SYNTHESIS
  // Both edge pulses must never be high in the same cycle.
  a_edges_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(r_edge_o && f_edge_o));
`endif

endmodule

// File: tb/tb_prim_debounce.sv
// Self-checking bench for prim_debounce. A behavioural model tracks how many
// consecutive enabled cycles the synchronized level has differed from the output.
// The output flips once that run reaches thresh+2.
module tb_prim_debounce;

  localparam int CntWidth   = 8;
  localparam int SyncStages = 2;
`ifdef PRIM_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic                serial = 1'b0;
  logic [CntWidth-1:0] thresh = 8'd3;
  logic                serial_o, busy_o, r_edge_o, f_edge_o;

  int checks   = 0;
  int failures = 0;

  prim_debounce #(
    .CntWidth  (CntWidth),
    .SyncStages(SyncStages)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .serial_i(serial),
    .thresh_i(thresh),
    .serial_o(serial_o),
    .busy_o  (busy_o),
    .r_edge_o(r_edge_o),
    .f_edge_o(f_edge_o)
  );

  always #5 clk = ~clk;

  // Reference model: input history plus a run length of disagreeing enabled cycles.
  logic [3:0] m_hist;
  int         m_run;
  logic       m_out, m_r, m_f;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist <= '0;
      m_run  <= 0;
      m_out  <= 1'b0;
      m_r    <= 1'b0;
      m_f    <= 1'b0;
    end else begin : model_step
      logic s_now;
      int   run_n;
      logic out_n;
      s_now = m_hist[SyncStages-1];
      run_n = m_run;
      out_n = m_out;
      m_r <= 1'b0;
      m_f <= 1'b0;
      if (!en || s_now == m_out) begin
        run_n = 0;
      end else begin
        run_n = m_run + 1;
        if (run_n >= int'(thresh) + 2) begin
          out_n = s_now;
          run_n = 0;
          m_r <= s_now;
          m_f <= !s_now;
        end
      end
      m_run  <= run_n;
      m_out  <= out_n;
      m_hist <= {m_hist[2:0], serial};
    end
  end

  wire [3:0] dut_vec = {serial_o, busy_o, r_edge_o, f_edge_o};
  wire [3:0] mdl_vec = {m_out, (m_run != 0), m_r & EdgeEn, m_f & EdgeEn};

  // Ends on a falling edge with reset released and inputs at defaults.
  task automatic do_reset(input logic [CntWidth-1:0] th);
    rst    = 1'b1;
    en     = 1'b1;
    serial = 1'b0;
    thresh = th;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async got=%b want=0000", dut_vec);
    end
    @(negedge clk);
    checks++;
    if (dut_vec !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held got=%b want=0000", dut_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency(input int th);
    int found;
    found = 0;
    do_reset(th[CntWidth-1:0]);
    serial = 1'b1;
    for (int k = 1; k <= th + 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL latency_model th=%0d cyc=%0d got=%b want=%b", th, k, dut_vec, mdl_vec);
      end
      if (found == 0 && serial_o === 1'b1) begin
        found = k;
        checks++;
        if (k != SyncStages + th + 2) begin
          failures++;
          $display("FAIL latency th=%0d got=%0d want=%0d", th, k, SyncStages + th + 2);
        end
        checks++;
        if (r_edge_o !== EdgeEn) begin
          failures++;
          $display("FAIL latency_redge th=%0d got=%b want=%b", th, r_edge_o, EdgeEn);
        end
      end
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL latency_timeout th=%0d got=no_rise want=rise", th);
    end
  endtask

  task automatic test_glitch();
    bit saw_busy, saw_edge;
    saw_busy = 1'b0;
    saw_edge = 1'b0;
    do_reset(8'd3);
    serial = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) serial = 1'b0;
      @(negedge clk);
      if (busy_o === 1'b1) saw_busy = 1'b1;
      if (r_edge_o !== 1'b0) saw_edge = 1'b1;
      checks++;
      if (serial_o !== 1'b0 || dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (saw_busy !== 1'b1 || busy_o !== 1'b0 || saw_edge !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got=saw%b/end%b/edge%b want=saw1/end0/edge0",
               saw_busy, busy_o, saw_edge);
    end
  endtask

  task automatic test_thresh_change();
    int k;
    do_reset(8'd10);
    serial = 1'b1;
    k = 0;
    while (m_run != 7 && k < 30) begin
      @(negedge clk);
      k++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL thchg_model cyc=%0d got=%b want=%b", k, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (m_run != 7 || busy_o !== 1'b1 || serial_o !== 1'b0) begin
      failures++;
      $display("FAIL thchg_setup got=busy%b/out%b want=busy1/out0", busy_o, serial_o);
    end
    thresh = 8'd2;
    @(negedge clk);
    checks++;
    if (serial_o !== 1'b1 || busy_o !== 1'b0 || r_edge_o !== EdgeEn) begin
      failures++;
      $display("FAIL thchg got=%b want=1 0 %b 0", dut_vec, EdgeEn);
    end
  endtask

  task automatic test_en_drop();
    int k;
    do_reset(8'd1);
    serial = 1'b1;
    k = 0;
    while (serial_o !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    serial = 1'b0;
    k = 0;
    while (m_run != 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy_o !== 1'b1 || serial_o !== 1'b1) begin
      failures++;
      $display("FAIL endrop_setup got=busy%b/out%b want=busy1/out1", busy_o, serial_o);
    end
    en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 4'b1000 || dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL endrop cyc=%0d got=%b want=1000", j, dut_vec);
      end
    end
    en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL endrop_resume cyc=%0d got=%b want=%b", j, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (serial_o !== 1'b0) begin
      failures++;
      $display("FAIL endrop_fall got=%b want=0", serial_o);
    end
  endtask

  task automatic test_reset_mid();
    int k, found;
    do_reset(8'd3);
    serial = 1'b1;
    k = 0;
    while (m_run != 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_async got=%b want=0000", dut_vec);
    end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    found = 0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL rstmid_model cyc=%0d got=%b want=%b", j, dut_vec, mdl_vec);
      end
      if (found == 0 && serial_o === 1'b1) found = j;
    end
    checks++;
    if (found != SyncStages + 3 + 2) begin
      failures++;
      $display("FAIL rstmid_latency got=%0d want=%0d", found, SyncStages + 5);
    end
  endtask

  task automatic test_random();
    do_reset(8'd2);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b want=%b", k, dut_vec, mdl_vec);
      end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) serial = ~serial;
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) thresh = 8'($urandom_range(0, 6));
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(8'd3);
    test_reset();
    test_latency(3);
    test_latency(0);
    test_latency(255);
    test_glitch();
    test_thresh_change();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
